// File: rtl/input_conditioner.sv
// Board input front end: synchronises the raw buttons and sound sensor, debounces the buttons,
// makes the start press a single pulse, qualifies restart with a long press, stretches sound.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned LONGPRESS_CYCLES = 50000000,
  parameter int unsigned HOLD_CYCLES      = 5000000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic START_RAW,
  input  logic RESTART_RAW,
  input  logic SOUND_RAW,
  output logic START_LEVEL,
  output logic START_PULSE,
  output logic RESTART_LEVEL,
  output logic RESTART_PULSE,
  output logic SOUND_EDGE,
  output logic SOUND_ACTIVE
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LpW   = $clog2(LONGPRESS_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LpW-1:0]   LpMax   = LpW'(LONGPRESS_CYCLES);
  localparam logic [LpW-1:0]   LpLast  = LpW'(LONGPRESS_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } btn_state_e;

  // Bit 0 = start, bit 1 = restart, bit 2 = sound
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  btn_state_e     r_btn_state [2];
  logic [DbW-1:0] r_btn_cnt   [2];
  logic [1:0]     r_btn_level;
  logic           r_start_pulse;

  logic [LpW-1:0] r_lp_cnt;
  logic           r_restart_pulse;

  logic             r_sound_prev;
  logic             r_sound_edge;
  logic [HoldW-1:0] r_hold_cnt;
  logic             r_sound_active;
  logic             w_sound_rise;

  assign w_raw = {SOUND_RAW, RESTART_RAW, START_RAW};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Both buttons share one debounce FSM; any glitch restarts the stability count.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 2; i++) begin
        r_btn_state[i] <= StIdle;
        r_btn_cnt[i]   <= '0;
      end
      r_btn_level   <= '0;
      r_start_pulse <= 1'b0;
    end else begin
      r_start_pulse <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        case (r_btn_state[i])
          StIdle: begin
            if (r_sync2[i]) begin
              r_btn_state[i] <= StPressWait;
              r_btn_cnt[i]   <= DbW'(1);
            end
          end
          StPressWait: begin
            if (!r_sync2[i]) begin
              r_btn_state[i] <= StIdle;
              r_btn_cnt[i]   <= '0;
            end else if (r_btn_cnt[i] == DbLast) begin
              r_btn_state[i] <= StPressed;
              r_btn_cnt[i]   <= '0;
              r_btn_level[i] <= 1'b1;
              if (i == 0) r_start_pulse <= 1'b1;
            end else begin
              r_btn_cnt[i] <= r_btn_cnt[i] + 1'b1;
            end
          end
          StPressed: begin
            if (!r_sync2[i]) begin
              r_btn_state[i] <= StReleaseWait;
              r_btn_cnt[i]   <= DbW'(1);
            end
          end
          StReleaseWait: begin
            if (r_sync2[i]) begin
              r_btn_state[i] <= StPressed;
              r_btn_cnt[i]   <= '0;
            end else if (r_btn_cnt[i] == DbLast) begin
              r_btn_state[i] <= StIdle;
              r_btn_cnt[i]   <= '0;
              r_btn_level[i] <= 1'b0;
            end else begin
              r_btn_cnt[i] <= r_btn_cnt[i] + 1'b1;
            end
          end
          default: begin
            r_btn_state[i] <= StIdle;
            r_btn_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Saturating hold counter: the pulse fires once, on the step into saturation.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_lp_cnt        <= '0;
      r_restart_pulse <= 1'b0;
    end else if (!r_btn_level[1]) begin
      r_lp_cnt        <= '0;
      r_restart_pulse <= 1'b0;
    end else if (r_lp_cnt != LpMax) begin
      r_lp_cnt        <= r_lp_cnt + 1'b1;
      r_restart_pulse <= (r_lp_cnt == LpLast);
    end else begin
      r_restart_pulse <= 1'b0;
    end
  end

  assign w_sound_rise = r_sync2[2] & ~r_sound_prev;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sound_prev   <= 1'b0;
      r_sound_edge   <= 1'b0;
      r_hold_cnt     <= '0;
      r_sound_active <= 1'b0;
    end else begin
      r_sound_prev <= r_sync2[2];
      r_sound_edge <= w_sound_rise;
      if (w_sound_rise) begin
        r_hold_cnt     <= HoldMax;
        r_sound_active <= 1'b1;
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt     <= r_hold_cnt - 1'b1;
        r_sound_active <= (r_hold_cnt > HoldW'(1));
      end else begin
        r_sound_active <= 1'b0;
      end
    end
  end

  assign START_LEVEL   = r_btn_level[0];
  assign START_PULSE   = r_start_pulse;
  assign RESTART_LEVEL = r_btn_level[1];
  assign RESTART_PULSE = r_restart_pulse;
  assign SOUND_EDGE    = r_sound_edge;
  assign SOUND_ACTIVE  = r_sound_active;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal waveforms plus a long randomized
// run, all checked every cycle against a rule-level model of the conditioner.
module tb_input_conditioner;

  localparam int D = 4;
  localparam int L = 16;
  localparam int H = 8;

  logic CLK, RST_n, START_RAW, RESTART_RAW, SOUND_RAW;
  logic START_LEVEL, START_PULSE, RESTART_LEVEL, RESTART_PULSE, SOUND_EDGE, SOUND_ACTIVE;

  input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .LONGPRESS_CYCLES(L),
    .HOLD_CYCLES     (H)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .START_RAW    (START_RAW),
    .RESTART_RAW  (RESTART_RAW),
    .SOUND_RAW    (SOUND_RAW),
    .START_LEVEL  (START_LEVEL),
    .START_PULSE  (START_PULSE),
    .RESTART_LEVEL(RESTART_LEVEL),
    .RESTART_PULSE(RESTART_PULSE),
    .SOUND_EDGE   (SOUND_EDGE),
    .SOUND_ACTIVE (SOUND_ACTIVE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: two-flop sync, last D synced samples per button, level run length, last edge time
  bit m_sync1 [3];
  bit m_s     [3];
  bit m_sprev;
  bit m_hist  [2][D];
  bit m_lvl   [2];
  int m_run;
  int m_cyc;
  int m_last_edge;
  bit m_have_edge;
  bit e_sl, e_sp, e_rl, e_rp, e_se, e_sa;

  task automatic model_clear();
    for (int b = 0; b < 3; b++) begin
      m_sync1[b] = 1'b0;
      m_s[b]     = 1'b0;
    end
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b0;
      for (int i = 0; i < D; i++) m_hist[b][i] = 1'b0;
    end
    m_sprev = 1'b0; m_run = 0; m_have_edge = 1'b0; m_last_edge = 0;
    e_sl = 0; e_sp = 0; e_rl = 0; e_rp = 0; e_se = 0; e_sa = 0;
  endtask

  task automatic model_step();
    bit old0, old1, all_flip;
    old0 = m_lvl[0];
    old1 = m_lvl[1];
    m_cyc++;
    // A level flips once the last D synced samples all disagree with it
    for (int b = 0; b < 2; b++) begin
      for (int i = D - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = m_s[b];
      all_flip = 1'b1;
      for (int i = 0; i < D; i++) if (m_hist[b][i] == m_lvl[b]) all_flip = 1'b0;
      if (all_flip) m_lvl[b] = ~m_lvl[b];
    end
    e_sl  = m_lvl[0];
    e_sp  = m_lvl[0] & ~old0;
    e_rl  = m_lvl[1];
    m_run = old1 ? m_run + 1 : 0;
    e_rp  = (m_run == L);
    e_se  = m_s[2] & ~m_sprev;
    if (e_se) begin
      m_have_edge = 1'b1;
      m_last_edge = m_cyc;
    end
    e_sa    = m_have_edge && ((m_cyc - m_last_edge) < H);
    m_sprev = m_s[2];
    for (int b = 0; b < 3; b++) m_s[b] = m_sync1[b];
    m_sync1[0] = START_RAW;
    m_sync1[1] = RESTART_RAW;
    m_sync1[2] = SOUND_RAW;
  endtask

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) model_clear();
    else        model_step();
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-scenario waveform logs: 0 sl, 1 sp, 2 rl, 3 rp, 4 se, 5 sa
  logic [63:0] lg [6];
  logic [63:0] ml [6];
  int sc = -1;
  bit chk_en = 1'b0;
  bit rnd_on = 1'b0;
  bit prev_sp = 1'b0;
  int dut_cnt [3];
  int mod_cnt [3];

  always @(negedge CLK) begin
    if (chk_en) begin
      chk1("start_level",   START_LEVEL,   e_sl);
      chk1("start_pulse",   START_PULSE,   e_sp);
      chk1("restart_level", RESTART_LEVEL, e_rl);
      chk1("restart_pulse", RESTART_PULSE, e_rp);
      chk1("sound_edge",    SOUND_EDGE,    e_se);
      chk1("sound_active",  SOUND_ACTIVE,  e_sa);
      chk1("start_pulse_double", START_PULSE & prev_sp, 1'b0);
      prev_sp = START_PULSE;
      if (rnd_on) begin
        dut_cnt[0] += int'(START_PULSE);
        dut_cnt[1] += int'(RESTART_PULSE);
        dut_cnt[2] += int'(SOUND_EDGE);
        mod_cnt[0] += int'(e_sp);
        mod_cnt[1] += int'(e_rp);
        mod_cnt[2] += int'(e_se);
      end
    end
    if (sc >= 0 && sc < 64) begin
      lg[0][sc] = START_LEVEL;   ml[0][sc] = e_sl;
      lg[1][sc] = START_PULSE;   ml[1][sc] = e_sp;
      lg[2][sc] = RESTART_LEVEL; ml[2][sc] = e_rl;
      lg[3][sc] = RESTART_PULSE; ml[3][sc] = e_rp;
      lg[4][sc] = SOUND_EDGE;    ml[4][sc] = e_se;
      lg[5][sc] = SOUND_ACTIVE;  ml[5][sc] = e_sa;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (sc >= 0) sc++;
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive(input int id, input int k);
    case (id)
      1: START_RAW   = (k >= 10);
      2: START_RAW   = (k >= 10 && k <= 12) || (k >= 14 && k <= 16);
      3: RESTART_RAW = (k >= 10 && k < 50);
      4: RESTART_RAW = (k >= 10 && k < 25);
      5: SOUND_RAW   = (k == 10) || (k == 17);
      6: begin
        RESTART_RAW = (k >= 10);
        RST_n       = !(k >= 14 && k < 20);
      end
      default: ;
    endcase
  endtask

  task automatic chk_sig(input string name, input int j, input logic [63:0] exp);
    chk64({name, "_dut"}, lg[j], exp);
    chk64({name, "_model"}, ml[j], exp);
  endtask

  task automatic run_scn(input int id);
    sc = -1;
    RST_n = 1'b0; START_RAW = 1'b0; RESTART_RAW = 1'b0; SOUND_RAW = 1'b0;
    tick(); tick(); tick();
    RST_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      lg[j] = '0;
      ml[j] = '0;
    end
    sc = 0;
    for (int k = 1; k < 64; k++) begin
      tick();
      drive(id, k);
    end
    @(negedge CLK);
    #1;
    sc = -1;
  endtask

  initial begin
    bit tgt_s, tgt_r;
    RST_n = 1'b0; START_RAW = 1'b0; RESTART_RAW = 1'b0; SOUND_RAW = 1'b0;
    for (int j = 0; j < 3; j++) begin
      dut_cnt[j] = 0;
      mod_cnt[j] = 0;
    end
    tick(); tick();
    chk_en = 1'b1;
    @(negedge CLK);
    chk1("reset_start_level", START_LEVEL, 1'b0);
    chk1("reset_restart_level", RESTART_LEVEL, 1'b0);
    chk1("reset_sound_active", SOUND_ACTIVE, 1'b0);
    tick();

    run_scn(1);
    chk_sig("t1_start_level", 0, rng(16, 63));
    chk_sig("t1_start_pulse", 1, rng(16, 16));

    run_scn(2);
    chk_sig("t2_bounce_level", 0, 64'd0);
    chk_sig("t2_bounce_pulse", 1, 64'd0);

    run_scn(3);
    chk_sig("t3_restart_level", 2, rng(16, 55));
    chk_sig("t3_restart_pulse", 3, rng(32, 32));

    run_scn(4);
    chk_sig("t3b_short_level", 2, rng(16, 30));
    chk_sig("t3b_short_pulse", 3, 64'd0);

    run_scn(5);
    chk_sig("t4_sound_edge", 4, rng(13, 13) | rng(20, 20));
    chk_sig("t4_sound_active", 5, rng(13, 27));

    run_scn(6);
    chk_sig("t5_restart_level", 2, rng(26, 63));
    chk_sig("t5_restart_pulse", 3, rng(42, 42));
    chk_sig("t5_sound_active", 5, 64'd0);

    // Randomized overlapping stimulus with bounce and occasional resets
    tgt_s = 1'b0;
    tgt_r = 1'b0;
    RST_n = 1'b1; START_RAW = 1'b0; RESTART_RAW = 1'b0; SOUND_RAW = 1'b0;
    rnd_on = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      tick();
      if ($urandom_range(0, 24) == 0) tgt_s = ~tgt_s;
      if ($urandom_range(0, 39) == 0) tgt_r = ~tgt_r;
      START_RAW   = tgt_s ^ ($urandom_range(0, 9) == 0);
      RESTART_RAW = tgt_r ^ ($urandom_range(0, 11) == 0);
      SOUND_RAW   = ($urandom_range(0, 14) == 0) || (SOUND_RAW && ($urandom_range(0, 1) == 1));
      if (RST_n && $urandom_range(0, 2999) == 0) RST_n = 1'b0;
      else if (!RST_n && $urandom_range(0, 2) == 0) RST_n = 1'b1;
    end
    @(negedge CLK);
    #1;
    rnd_on = 1'b0;
    chk_int("rnd_start_pulse_count", dut_cnt[0], mod_cnt[0]);
    chk_int("rnd_restart_pulse_count", dut_cnt[1], mod_cnt[1]);
    chk_int("rnd_sound_edge_count", dut_cnt[2], mod_cnt[2]);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
